reg_dump_streamer: RTL

- Reader for the register bank's debug show port.
- On a start pulse, walks a range of register addresses on the show-address output and captures each 64-bit value into a shadow register.
- Streams each captured value as BEATS narrow beats over a valid/ready link to the debug/display path.
- Sits beside the register bank in the processor top level. Never touches the bank's write port.

---
 rtl/reg_dump_streamer_pkg.sv | 28 ++
 rtl/reg_dump_streamer_if.sv | 26 ++
 rtl/reg_dump_streamer_beat_serializer.sv | 53 +++++
 rtl/reg_dump_streamer.sv | 104 ++++++++++
 4 files changed

// File: rtl/reg_dump_streamer_pkg.sv
// Shared constants and types for the register-bank debug dump path.
// Used by reg_dump_streamer, the register bank and their benches.
package reg_dump_streamer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2,
        DONE  = 2'd3
    } dump_state_t;

    localparam int          REG_COUNT = 32;
    localparam logic [4:0]  SP_INDEX  = 5'd28;
    localparam logic [63:0] SP_RESET  = 64'h7fffeffc;
    localparam logic [4:0]  XZR_INDEX = 5'd31;

    // Width of a beat counter for a given beat count (at least 1 bit).
    function automatic int idx_width(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

    localparam int DEF_DATA_WIDTH = 64;
    localparam int DEF_BEAT_WIDTH = 16;
    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_BEAT_IDX_W =
        idx_width(DEF_DATA_WIDTH / DEF_BEAT_WIDTH);

endpackage

// File: rtl/reg_dump_streamer_if.sv
// Beat stream from the dump streamer to the debug/display path.
// master: oData/oValid/oRegIndex/oBeat/oLast out, iReady in; slave mirrors it.
interface reg_dump_streamer_if
    import reg_dump_streamer_pkg::*;
#(
    parameter int BEAT_WIDTH = DEF_BEAT_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int BEAT_IDX_W = DEF_BEAT_IDX_W
);
    logic [BEAT_WIDTH-1:0] oData;
    logic                  oValid;
    logic                  iReady;
    logic [ADDR_WIDTH-1:0] oRegIndex;
    logic [BEAT_IDX_W-1:0] oBeat;
    logic                  oLast;

    modport master (
        output oData, oValid, oRegIndex, oBeat, oLast,
        input  iReady
    );

    modport slave (
        input  oData, oValid, oRegIndex, oBeat, oLast,
        output iReady
    );
endinterface

// File: rtl/reg_dump_streamer_beat_serializer.sv
// Captures one wide word into a shadow register and emits it as narrow
// beats, LSB first, over valid/ready.
// Ports: clk, rst (sync, active high), load (capture din), din, ready in;
// data, valid, beat, last_beat, done (handshake on the final beat) out.
module beat_serializer #(
    parameter int DATA_WIDTH = 64,
    parameter int BEAT_WIDTH = 16,
    parameter int BEAT_IDX_W = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  ready,
    output logic [BEAT_WIDTH-1:0] data,
    output logic                  valid,
    output logic [BEAT_IDX_W-1:0] beat,
    output logic                  last_beat,
    output logic                  done
);
    localparam int BEATS = DATA_WIDTH / BEAT_WIDTH;
    localparam logic [BEAT_IDX_W-1:0] BEAT_MAX = BEAT_IDX_W'(BEATS - 1);

    logic [DATA_WIDTH-1:0] shadow;

    assign last_beat = (beat == BEAT_MAX);
    assign done      = valid && ready && last_beat;

    always_comb begin
        data = shadow[int'(beat) * BEAT_WIDTH +: BEAT_WIDTH];
    end

    // The shadow is written only on load, so the word being streamed is
    // immune to bank writes after its capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow <= '0;
            beat   <= '0;
            valid  <= 1'b0;
        end else if (load) begin
            shadow <= din;
            beat   <= '0;
            valid  <= 1'b1;
        end else if (valid && ready) begin
            if (last_beat) begin
                valid <= 1'b0;
            end else begin
                beat <= beat + 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_dump_streamer.sv
// Walks a register range on the bank's show port and streams each value.
// Ports: iCLK, iReset, iStart, iFirstReg, iLastReg, iShowData in; oShowAddr,
// oBusy, oDone out; dump (master) carries the beat stream.
module reg_dump_streamer
    import reg_dump_streamer_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int BEAT_WIDTH = DEF_BEAT_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  iCLK,
    input  logic                  iReset,
    input  logic                  iStart,
    input  logic [ADDR_WIDTH-1:0] iFirstReg,
    input  logic [ADDR_WIDTH-1:0] iLastReg,
    output logic [ADDR_WIDTH-1:0] oShowAddr,
    input  logic [DATA_WIDTH-1:0] iShowData,
    output logic                  oBusy,
    output logic                  oDone,
    reg_dump_streamer_if.master   dump
);
    localparam int BEATS      = DATA_WIDTH / BEAT_WIDTH;
    localparam int BEAT_IDX_W = idx_width(BEATS);

    dump_state_t           state_q;
    dump_state_t           state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] last_q;
    logic                  load;
    logic                  reg_done;
    logic                  last_beat;
    logic                  at_last;

    assign at_last = (addr_q == last_q);

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (iStart) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                load    = 1'b1;
                state_d = SEND;
            end
            SEND: begin
                if (reg_done) begin
                    state_d = at_last ? DONE : FETCH;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Address advances on the final handshake of a register; the
    // ADDR_WIDTH-bit counter wraps 31 -> 0 on its own.
    always_ff @(posedge iCLK) begin
        if (iReset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            last_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && iStart) begin
                addr_q <= iFirstReg;
                last_q <= iLastReg;
            end else if (state_q == SEND && reg_done && !at_last) begin
                addr_q <= addr_q + 1'b1;
            end
        end
    end

    beat_serializer #(
        .DATA_WIDTH (DATA_WIDTH),
        .BEAT_WIDTH (BEAT_WIDTH),
        .BEAT_IDX_W (BEAT_IDX_W)
    ) u_ser (
        .clk       (iCLK),
        .rst       (iReset),
        .load      (load),
        .din       (iShowData),
        .ready     (dump.iReady),
        .data      (dump.oData),
        .valid     (dump.oValid),
        .beat      (dump.oBeat),
        .last_beat (last_beat),
        .done      (reg_done)
    );

    assign oShowAddr      = addr_q;
    assign dump.oRegIndex = addr_q;
    assign dump.oLast     = dump.oValid && last_beat && at_last;
    assign oBusy          = (state_q != IDLE);
    assign oDone          = (state_q == DONE);

endmodule
